// File: rtl/scan_group_mux_initiator.sv
// scan_group_mux_initiator
// Initiator side of the group_mux static-access protocol. A 54-bit serial
// scan register is loaded with {wen, ren, addr[19:0], wdata[31:0]} (LSB
// first), an edge on scan_update launches the access, and the status/result
// frame is shifted back out through the same register.
//
// Optional feature: define TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES cycles; an expired wait returns status 2'b11 and data
// 32'hDEAD_DEAD.
module scan_group_mux_initiator #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_in,
  input  logic        scan_shift,
  input  logic        scan_update,
  output logic        scan_out,
  output logic        busy,
  output logic        static_wen_group_mux,
  output logic        static_ren_group_mux,
  output logic [19:0] static_addr_group_mux,
  output logic [31:0] static_wdata_group_mux,
  output logic        scan_id_group_mux,
  input  logic [31:0] static_rdata_group_mux,
  input  logic        static_ready_group_mux
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ASSERT,
    S_WAIT,
    S_RELEASE,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b01;
  localparam logic [1:0] ST_INVALID = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  // Parameter sanity: setup needs at least one cycle and the counter must be
  // wide enough to reach the timeout limit.
  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("SETUP_CYCLES must be at least 1");
  end
  if (CNT_W < $clog2(TIMEOUT_CYCLES + 1) || CNT_W < $clog2(SETUP_CYCLES + 1)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for SETUP_CYCLES/TIMEOUT_CYCLES");
  end

  state_t             state;
  logic [53:0]        shreg;
  logic [CNT_W-1:0]   cnt;
  logic               update_q;
  logic               update_edge;
  logic               cmd_valid;
  logic               wait_expired;

  assign update_edge = scan_update & ~update_q;
  assign cmd_valid   = shreg[53] ^ shreg[52];
  assign scan_out    = shreg[0];

`ifdef TIMEOUT_EN
  assign wait_expired = (cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign wait_expired = 1'b0;
`endif

  // Previous scan_update level, tracked in every state so a level held
  // through a busy period cannot re-launch once the FSM returns to DONE.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) update_q <= 1'b0;
    else        update_q <= scan_update;
  end

  // Transaction FSM, scan register and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= S_IDLE;
      // NOTE: the scan register is reset explicitly; it is the status frame
      // read back after reset, so it must not power up with junk.
      shreg                  <= '0;
      cnt                    <= '0;
      busy                   <= 1'b0;
      static_wen_group_mux   <= 1'b0;
      static_ren_group_mux   <= 1'b0;
      static_addr_group_mux  <= '0;
      static_wdata_group_mux <= '0;
      scan_id_group_mux      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (update_edge) begin
            // An update edge takes priority over a simultaneous shift.
            if (cmd_valid) begin
              state                  <= S_SETUP;
              busy                   <= 1'b1;
              cnt                    <= '0;
              static_wen_group_mux   <= shreg[53];
              static_ren_group_mux   <= shreg[52];
              static_addr_group_mux  <= shreg[51:32];
              static_wdata_group_mux <= shreg[31:0];
            end else begin
              shreg[53:52] <= ST_INVALID;
              state        <= S_DONE;
            end
          end else if (scan_shift) begin
            shreg <= {scan_in, shreg[53:1]};
          end
        end

        S_SETUP: begin
          if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            state             <= S_ASSERT;
            scan_id_group_mux <= 1'b1;
            cnt               <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Ready is deliberately not sampled here; the responder cannot have
        // seen scan_id yet.
        S_ASSERT: begin
          state <= S_WAIT;
          cnt   <= '0;
        end

        S_WAIT: begin
          if (static_ready_group_mux || wait_expired) begin
            state                  <= S_RELEASE;
            scan_id_group_mux      <= 1'b0;
            static_wen_group_mux   <= 1'b0;
            static_ren_group_mux   <= 1'b0;
            static_addr_group_mux  <= '0;
            static_wdata_group_mux <= '0;
            if (static_ready_group_mux) begin
              shreg[53:52] <= ST_OK;
              shreg[31:0]  <= static_ren_group_mux ? static_rdata_group_mux
                                                   : static_wdata_group_mux;
            end else begin
              shreg[53:52] <= ST_TIMEOUT;
              shreg[31:0]  <= 32'hDEAD_DEAD;
            end
          end else begin
`ifdef TIMEOUT_EN
            cnt <= cnt + 1'b1;
`endif
          end
        end

        // Hold off until the responder drops ready so the next access does
        // not complete on a stale handshake.
        S_RELEASE: begin
          if (!static_ready_group_mux) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_group_mux_initiator.sv
// Directed self-checking bench for scan_group_mux_initiator.
// Runs with SETUP_CYCLES=2 and TIMEOUT_CYCLES=16; the timeout scenario is
// only exercised when TIMEOUT_EN is defined.
module tb_scan_group_mux_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_in = 1'b0;
  logic        scan_shift = 1'b0;
  logic        scan_update = 1'b0;
  logic        scan_out;
  logic        busy;
  logic        static_wen_group_mux;
  logic        static_ren_group_mux;
  logic [19:0] static_addr_group_mux;
  logic [31:0] static_wdata_group_mux;
  logic        scan_id_group_mux;
  logic [31:0] static_rdata_group_mux = '0;
  logic        static_ready_group_mux = 1'b0;

  int checks = 0;
  int errors = 0;

  scan_group_mux_initiator #(
    .SETUP_CYCLES  (2),
    .TIMEOUT_CYCLES(16),
    .CNT_W         (11)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .scan_in               (scan_in),
    .scan_shift            (scan_shift),
    .scan_update           (scan_update),
    .scan_out              (scan_out),
    .busy                  (busy),
    .static_wen_group_mux  (static_wen_group_mux),
    .static_ren_group_mux  (static_ren_group_mux),
    .static_addr_group_mux (static_addr_group_mux),
    .static_wdata_group_mux(static_wdata_group_mux),
    .scan_id_group_mux     (scan_id_group_mux),
    .static_rdata_group_mux(static_rdata_group_mux),
    .static_ready_group_mux(static_ready_group_mux)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; all driving and sampling
  // happens here, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift a full 54-bit frame in while capturing the frame shifted out.
  task automatic shift_frame(input logic [53:0] din, output logic [53:0] dout);
    for (int i = 0; i < 54; i++) begin
      scan_in    = din[i];
      scan_shift = 1'b1;
      dout[i]    = scan_out;
      tick();
    end
    scan_shift = 1'b0;
    scan_in    = 1'b0;
  endtask

  // Launch the loaded command; returns the number of edges, counted from the
  // edge that samples the update, until scan_id is seen high (bounded).
  task automatic launch(output int n);
    scan_update = 1'b1;
    tick();
    scan_update = 1'b0;
    n = 1;
    while (!scan_id_group_mux && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [53:0] frame;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, static_wen_group_mux, static_ren_group_mux, scan_id_group_mux,
         static_addr_group_mux, static_wdata_group_mux, scan_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b wen=%b ren=%b id=%b addr=%h wdata=%h so=%b required all 0",
               busy, static_wen_group_mux, static_ren_group_mux, scan_id_group_mux,
               static_addr_group_mux, static_wdata_group_mux, scan_out);
    end
    #3 rst_n = 1'b1;
    tick();
    shift_frame('0, frame);
    checks++;
    if (frame !== 54'h0) begin
      errors++;
      $display("FAIL reset_shreg: got %h required 0", frame);
    end
  endtask

  task automatic test_read();
    logic [53:0] frame;
    int n;
    shift_frame({1'b0, 1'b1, 20'h00ABC, 32'h0}, frame);
    launch(n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL read_latency: got %0d required 3", n);
    end
    checks++;
    if ({static_ren_group_mux, static_wen_group_mux, static_addr_group_mux} !== {1'b1, 1'b0, 20'h00ABC}) begin
      errors++;
      $display("FAIL read_request: got ren=%b wen=%b addr=%h required ren=1 wen=0 addr=00abc",
               static_ren_group_mux, static_wen_group_mux, static_addr_group_mux);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (scan_id_group_mux !== 1'b1) begin
        errors++;
        $display("FAIL read_id_held: cycle %0d got %b required 1", k, scan_id_group_mux);
      end
    end
    static_ready_group_mux = 1'b1;
    static_rdata_group_mux = 32'h1234_5678;
    tick();
    checks++;
    if ({busy, scan_id_group_mux, static_ren_group_mux, static_addr_group_mux} !== {1'b1, 1'b0, 1'b0, 20'h0}) begin
      errors++;
      $display("FAIL read_release: got busy=%b id=%b ren=%b addr=%h required busy=1 id=0 ren=0 addr=0",
               busy, scan_id_group_mux, static_ren_group_mux, static_addr_group_mux);
    end
    static_ready_group_mux = 1'b0;
    static_rdata_group_mux = '0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL read_done_busy: got %b required 0", busy);
    end
    shift_frame('0, frame);
    checks++;
    if (frame !== {2'b01, 20'h00ABC, 32'h1234_5678}) begin
      errors++;
      $display("FAIL read_frame: got %h required %h", frame, {2'b01, 20'h00ABC, 32'h1234_5678});
    end
  endtask

  task automatic test_write();
    logic [53:0] frame;
    int n;
    int bad;
    shift_frame({1'b1, 1'b0, 20'h00010, 32'hCAFE_F00D}, frame);
    scan_update = 1'b1;
    tick();
    scan_update = 1'b0;
    // Sample the request on every cycle from SETUP through WAIT.
    bad = 0;
    for (n = 0; n < 7; n++) begin
      if (static_wdata_group_mux !== 32'hCAFE_F00D || static_wen_group_mux !== 1'b1 ||
          static_addr_group_mux !== 20'h00010) bad++;
      if (n < 6) tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL write_stable: %0d unstable cycles, required 0 (wdata=%h)", bad, static_wdata_group_mux);
    end
    checks++;
    if (scan_id_group_mux !== 1'b1) begin
      errors++;
      $display("FAIL write_id: got %b required 1", scan_id_group_mux);
    end
    static_ready_group_mux = 1'b1;
    static_rdata_group_mux = 32'h5555_5555;
    tick();
    checks++;
    if ({busy, static_wen_group_mux, scan_id_group_mux, static_wdata_group_mux} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL write_release: got busy=%b wen=%b id=%b wdata=%h required busy=1 wen=0 id=0 wdata=0",
               busy, static_wen_group_mux, scan_id_group_mux, static_wdata_group_mux);
    end
    static_ready_group_mux = 1'b0;
    static_rdata_group_mux = '0;
    tick();
    shift_frame('0, frame);
    checks++;
    if (frame !== {2'b01, 20'h00010, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL write_frame: got %h required %h", frame, {2'b01, 20'h00010, 32'hCAFE_F00D});
    end
  endtask

  task automatic test_invalid();
    logic [53:0] frame;
    logic [53:0] cmds [2];
    int busy_cycles;
    int activity;
    cmds[0] = {1'b1, 1'b1, 20'h12345, 32'hAAAA_5555};
    cmds[1] = {1'b0, 1'b0, 20'h0F00F, 32'h0000_0001};
    for (int c = 0; c < 2; c++) begin
      shift_frame(cmds[c], frame);
      scan_update = 1'b1;
      busy_cycles = 0;
      activity = 0;
      for (int k = 0; k < 4; k++) begin
        tick();
        scan_update = 1'b0;
        if (busy) busy_cycles++;
        if (static_wen_group_mux || static_ren_group_mux || scan_id_group_mux) activity++;
      end
      checks++;
      if (activity !== 0 || busy_cycles > 1) begin
        errors++;
        $display("FAIL invalid_activity[%0d]: got %0d active, %0d busy cycles required 0 and <=1",
                 c, activity, busy_cycles);
      end
      shift_frame('0, frame);
      checks++;
      if (frame !== {2'b10, cmds[c][51:0]}) begin
        errors++;
        $display("FAIL invalid_frame[%0d]: got %h required %h", c, frame, {2'b10, cmds[c][51:0]});
      end
    end
  endtask

  task automatic test_ignore_during_wait();
    logic [53:0] frame;
    int n;
    int rises;
    logic id_q;
    shift_frame({1'b0, 1'b1, 20'h00F0F, 32'h0000_0001}, frame);
    launch(n);
    rises = scan_id_group_mux ? 1 : 0;
    id_q  = scan_id_group_mux;
    tick();
    tick();
    // Second update pulse plus shifting of ones, both while in WAIT.
    scan_update = 1'b1;
    tick();
    scan_update = 1'b0;
    scan_in = 1'b1;
    scan_shift = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (scan_id_group_mux && !id_q) rises++;
      id_q = scan_id_group_mux;
    end
    scan_shift = 1'b0;
    scan_in = 1'b0;
    checks++;
    if (scan_out !== 1'b1) begin
      errors++;
      $display("FAIL ignore_shift: scan_out got %b required 1", scan_out);
    end
    static_ready_group_mux = 1'b1;
    static_rdata_group_mux = 32'h0BAD_BEEF;
    tick();
    static_ready_group_mux = 1'b0;
    static_rdata_group_mux = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (scan_id_group_mux && !id_q) rises++;
      id_q = scan_id_group_mux;
    end
    checks++;
    if (rises !== 1) begin
      errors++;
      $display("FAIL ignore_single_id: got %0d scan_id assertions required 1", rises);
    end
    shift_frame('0, frame);
    checks++;
    if (frame !== {2'b01, 20'h00F0F, 32'h0BAD_BEEF}) begin
      errors++;
      $display("FAIL ignore_frame: got %h required %h", frame, {2'b01, 20'h00F0F, 32'h0BAD_BEEF});
    end
  endtask

  task automatic test_ready_held();
    logic [53:0] frame;
    int n;
    shift_frame({1'b0, 1'b1, 20'h00123, 32'h0}, frame);
    launch(n);
    tick();
    static_ready_group_mux = 1'b1;
    static_rdata_group_mux = 32'h8765_4321;
    tick();
    // Now in RELEASE; keep ready high for this and three further cycles.
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (n == 4) static_ready_group_mux = 1'b0;
      tick();
    end
    static_rdata_group_mux = '0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL ready_held_release: busy cycles in release got %0d required 4", n);
    end
    shift_frame('0, frame);
    checks++;
    if (frame !== {2'b01, 20'h00123, 32'h8765_4321}) begin
      errors++;
      $display("FAIL ready_held_frame: got %h required %h", frame, {2'b01, 20'h00123, 32'h8765_4321});
    end
  endtask

`ifdef TIMEOUT_EN
  task automatic test_timeout();
    logic [53:0] frame;
    int n;
    shift_frame({1'b0, 1'b1, 20'h00777, 32'h0}, frame);
    launch(n);
    // scan_id rose on the ASSERT edge; WAIT starts one edge later and the
    // abort lands 17 edges into WAIT, i.e. 18 edges after the rise.
    n = 0;
    while (scan_id_group_mux && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 18) begin
      errors++;
      $display("FAIL timeout_latency: got %0d required 18", n);
    end
    tick();
    shift_frame('0, frame);
    checks++;
    if (frame !== {2'b11, 20'h00777, 32'hDEAD_DEAD}) begin
      errors++;
      $display("FAIL timeout_frame: got %h required %h", frame, {2'b11, 20'h00777, 32'hDEAD_DEAD});
    end
  endtask
`endif

  task automatic test_async_reset();
    logic [53:0] frame;
    int n;
    shift_frame({1'b1, 1'b0, 20'hFFFFF, 32'hFFFF_FFFF}, frame);
    launch(n);
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, static_wen_group_mux, static_ren_group_mux, scan_id_group_mux,
         static_addr_group_mux, static_wdata_group_mux, scan_out} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got busy=%b wen=%b id=%b addr=%h wdata=%h so=%b required all 0",
               busy, static_wen_group_mux, scan_id_group_mux, static_addr_group_mux,
               static_wdata_group_mux, scan_out);
    end
    #1 rst_n = 1'b1;
    tick();
    shift_frame('0, frame);
    checks++;
    if (frame !== 54'h0) begin
      errors++;
      $display("FAIL async_reset_shreg: got %h required 0", frame);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_invalid();
    test_ignore_during_wait();
    test_ready_held();
`ifdef TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
